// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states and
// access-size / alignment helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } lsu_state_e;

   // funct3[1:0] encodes log2 of the access size in bytes.
   function automatic int unsigned size_bytes(input logic [2:0] funct3);
      return 32'd1 << funct3[1:0];
   endfunction

   function automatic logic is_legal(input logic [2:0] funct3, input int unsigned xlen);
      case (funct3)
         F3_D, F3_WU: return xlen == 64;
         3'b111:      return 1'b0;
         default:     return 1'b1;
      endcase
   endfunction

   // Illegal encodings for the configured XLEN report as misaligned.
   function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] offset,
                                       input int unsigned xlen);
      logic [2:0] mask;
      mask = 3'(size_bytes(funct3) - 1);
      return is_legal(funct3, xlen) && ((offset & mask) == 3'b000);
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side and memory-side signals of the load/store unit. The slave modport is the
// unit's own view; master is the view of whatever drives it (pipeline plus memory).
interface load_store_unit_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
);
   logic                  i_valid;
   logic                  o_ready;
   logic                  i_re;
   logic                  i_we;
   logic [2:0]            i_funct3;
   logic [ADDR_W-1:0]     i_addr;
   logic [XLEN-1:0]       i_wdata;
   logic                  o_valid;
   logic [XLEN-1:0]       o_rdata;
   logic                  o_misaligned;
   logic                  o_stall;
   logic                  o_mem_req;
   logic                  i_mem_gnt;
   logic [ADDR_W-1:0]     o_mem_addr;
   logic                  o_mem_we;
   logic [XLEN/8-1:0]     o_mem_be;
   logic [XLEN-1:0]       o_mem_wdata;
   logic                  i_mem_rvalid;
   logic [XLEN-1:0]       i_mem_rdata;

   modport slave (
      input  i_valid, i_re, i_we, i_funct3, i_addr, i_wdata, i_mem_gnt, i_mem_rvalid,
             i_mem_rdata,
      output o_ready, o_valid, o_rdata, o_misaligned, o_stall, o_mem_req, o_mem_addr,
             o_mem_we, o_mem_be, o_mem_wdata
   );

   modport master (
      output i_valid, i_re, i_we, i_funct3, i_addr, i_wdata, i_mem_gnt, i_mem_rvalid,
             i_mem_rdata,
      input  o_ready, o_valid, o_rdata, o_misaligned, o_stall, o_mem_req, o_mem_addr,
             o_mem_we, o_mem_be, o_mem_wdata
   );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and data steering, and load lane
// extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   localparam int unsigned NB    = XLEN / 8,
   localparam int unsigned OFF_W = $clog2(NB)
) (
   input  logic [2:0]       st_funct3_i,
   input  logic [OFF_W-1:0] st_offset_i,
   input  logic [XLEN-1:0]  st_wdata_i,
   output logic [NB-1:0]    st_be_o,
   output logic [XLEN-1:0]  st_wdata_o,
   input  logic [2:0]       ld_funct3_i,
   input  logic [OFF_W-1:0] ld_offset_i,
   input  logic [XLEN-1:0]  ld_rdata_i,
   output logic [XLEN-1:0]  ld_rdata_o
);
   localparam int unsigned IDX_W = $clog2(XLEN);

   logic [XLEN-1:0]  ld_shifted;
   logic [IDX_W-1:0] ld_msb;
   logic             ld_fill;
   int unsigned      ld_bits;

   always_comb begin
      st_be_o    = NB'((32'd1 << size_bytes(st_funct3_i)) - 32'd1) << st_offset_i;
      st_wdata_o = st_wdata_i << {st_offset_i, 3'b000};
   end

   always_comb begin
      ld_shifted = ld_rdata_i >> {ld_offset_i, 3'b000};
      ld_bits    = size_bytes(ld_funct3_i) * 8;
      if (ld_bits > XLEN) ld_bits = XLEN;
      ld_msb     = IDX_W'(ld_bits - 1);
      // funct3[2] marks the unsigned variants.
      ld_fill    = ~ld_funct3_i[2] & ld_shifted[ld_msb];
      ld_rdata_o = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         ld_rdata_o[i] = (i < ld_bits) ? ld_shifted[i] : ld_fill;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, faults misaligned ones locally and
// otherwise runs a req/gnt/rvalid transaction on the data-memory port.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.slave  bus
);
   localparam int unsigned NB    = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(NB);

   lsu_state_e        state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [OFF_W-1:0]  offset_q, offset_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic              valid_q, valid_d;
   logic              misaligned_q, misaligned_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;

   logic [NB-1:0]     st_be;
   logic [XLEN-1:0]   st_wdata;
   logic [XLEN-1:0]   ld_rdata;
   logic              accept;
   logic              aligned;

   lsu_align #(
      .XLEN (XLEN)
   ) u_align (
      .st_funct3_i (bus.i_funct3),
      .st_offset_i (bus.i_addr[OFF_W-1:0]),
      .st_wdata_i  (bus.i_wdata),
      .st_be_o     (st_be),
      .st_wdata_o  (st_wdata),
      .ld_funct3_i (funct3_q),
      .ld_offset_i (offset_q),
      .ld_rdata_i  (bus.i_mem_rdata),
      .ld_rdata_o  (ld_rdata)
   );

   assign accept  = bus.i_valid && (bus.i_re || bus.i_we) && (state_q == StIdle);
   assign aligned = is_aligned(bus.i_funct3, bus.i_addr[2:0], XLEN);

   always_comb begin
      state_d      = state_q;
      funct3_d     = funct3_q;
      offset_d     = offset_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_be_d     = mem_be_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      valid_d      = 1'b0;
      misaligned_d = 1'b0;
      rdata_d      = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               funct3_d = bus.i_funct3;
               offset_d = bus.i_addr[OFF_W-1:0];
               if (aligned) begin
                  state_d     = StReq;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.i_we;
                  mem_be_d    = st_be;
                  mem_wdata_d = st_wdata;
                  mem_addr_d  = {bus.i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
               end else begin
                  valid_d      = 1'b1;
                  misaligned_d = 1'b1;
                  rdata_d      = '0;
               end
            end
         end
         StReq: begin
            if (bus.i_mem_gnt) begin
               mem_req_d = 1'b0;
               if (mem_we_q) begin
                  state_d = StIdle;
                  valid_d = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (bus.i_mem_rvalid) begin
               state_d = StIdle;
               valid_d = 1'b1;
               rdata_d = ld_rdata;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         funct3_q     <= '0;
         offset_q     <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         offset_q     <= offset_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_be_q     <= mem_be_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         valid_q      <= valid_d;
         misaligned_q <= misaligned_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.o_ready      = (state_q == StIdle);
   assign bus.o_stall      = (state_q != StIdle);
   assign bus.o_valid      = valid_q;
   assign bus.o_misaligned = misaligned_q;
   assign bus.o_rdata      = rdata_q;
   assign bus.o_mem_req    = mem_req_q;
   assign bus.o_mem_we     = mem_we_q;
   assign bus.o_mem_be     = mem_be_q;
   assign bus.o_mem_addr   = mem_addr_q;
   assign bus.o_mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses on a 32-bit instance,
// and a few directed accesses on a 64-bit instance.
module tb_load_store_unit;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   load_store_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
   load_store_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

   load_store_unit #(.XLEN(32), .ADDR_W(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
   load_store_unit #(.XLEN(64), .ADDR_W(32)) u64 (.clk(clk), .rst_n(rst_n), .bus(b64));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference model, from the access rules rather than the lane hardware.
   function automatic int unsigned sz(input logic [2:0] f3);
      case (f3[1:0])
         2'd0: return 1;
         2'd1: return 2;
         2'd2: return 4;
         default: return 8;
      endcase
   endfunction

   function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] addr,
                                 input int unsigned xlen);
      if (f3 == 3'd7) return 1'b1;
      if (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) return 1'b1;
      return (addr % sz(f3)) != 0;
   endfunction

   function automatic longint unsigned ld_model(input logic [2:0] f3, input logic [31:0] addr,
                                                input longint unsigned word,
                                                input int unsigned xlen);
      int unsigned       off  = addr % (xlen / 8);
      int unsigned       bits = sz(f3) * 8;
      longint unsigned   mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 1);
      longint unsigned   v    = (word >> (8 * off)) & mask;
      if (!f3[2] && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
      if (xlen == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic access32(input string tag, input bit re, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input int gd,
                           input logic [31:0] word, input int rd);
      bit               m = is_mis(f3, addr, 32);
      int unsigned      off = addr % 4;
      logic [31:0]      exp_be = 32'(((64'd1 << sz(f3)) - 1) << off);
      logic [31:0]      exp_wd = 32'({32'd0, wdata} << (8 * off));
      logic [31:0]      exp_rd;
      b32.i_valid = 1'b1; b32.i_re = re; b32.i_we = we;
      b32.i_funct3 = f3; b32.i_addr = addr; b32.i_wdata = wdata;
      tick();
      b32.i_valid = 1'b0; b32.i_re = 1'b0; b32.i_we = 1'b0;
      if (m) begin
         chk({tag, " mis valid"}, b32.o_valid, 1);
         chk({tag, " mis flag"}, b32.o_misaligned, 1);
         chk({tag, " mis rdata"}, b32.o_rdata, 0);
         chk({tag, " mis req"}, b32.o_mem_req, 0);
         tick();
         chk({tag, " mis valid drop"}, b32.o_valid, 0);
         chk({tag, " mis req late"}, b32.o_mem_req, 0);
         return;
      end
      for (int i = 0; i <= gd; i++) begin
         chk({tag, " req"}, b32.o_mem_req, 1);
         chk({tag, " stall"}, b32.o_stall, 1);
         chk({tag, " addr"}, b32.o_mem_addr, addr & 32'hFFFF_FFFC);
         chk({tag, " we"}, b32.o_mem_we, we);
         chk({tag, " no valid"}, b32.o_valid, 0);
         if (we) begin
            chk({tag, " be"}, b32.o_mem_be, exp_be[3:0]);
            chk({tag, " wdata"}, b32.o_mem_wdata, exp_wd);
         end
         if (i == gd) b32.i_mem_gnt = 1'b1;
         tick();
      end
      b32.i_mem_gnt = 1'b0;
      if (we) begin
         chk({tag, " st valid"}, b32.o_valid, 1);
         chk({tag, " st mis"}, b32.o_misaligned, 0);
         chk({tag, " st rdata"}, b32.o_rdata, 0);
         chk({tag, " st ready"}, b32.o_ready, 1);
         chk({tag, " st req off"}, b32.o_mem_req, 0);
         exp_rd = 32'd0;
      end else begin
         chk({tag, " ld req off"}, b32.o_mem_req, 0);
         chk({tag, " ld wait stall"}, b32.o_stall, 1);
         chk({tag, " ld wait valid"}, b32.o_valid, 0);
         repeat (rd) tick();
         b32.i_mem_rvalid = 1'b1; b32.i_mem_rdata = word;
         tick();
         b32.i_mem_rvalid = 1'b0;
         exp_rd = 32'(ld_model(f3, addr, {32'd0, word}, 32));
         chk({tag, " ld valid"}, b32.o_valid, 1);
         chk({tag, " ld mis"}, b32.o_misaligned, 0);
         chk({tag, " ld rdata"}, b32.o_rdata, exp_rd);
      end
      tick();
      chk({tag, " valid drop"}, b32.o_valid, 0);
      chk({tag, " rdata hold"}, b32.o_rdata, exp_rd);
   endtask

   initial begin
      {b32.i_valid, b32.i_re, b32.i_we, b32.i_mem_gnt, b32.i_mem_rvalid} = '0;
      b32.i_funct3 = '0; b32.i_addr = '0; b32.i_wdata = '0; b32.i_mem_rdata = '0;
      {b64.i_valid, b64.i_re, b64.i_we, b64.i_mem_gnt, b64.i_mem_rvalid} = '0;
      b64.i_funct3 = '0; b64.i_addr = '0; b64.i_wdata = '0; b64.i_mem_rdata = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst valid", b32.o_valid, 0);
      chk("rst req", b32.o_mem_req, 0);
      chk("rst be", b32.o_mem_be, 0);
      chk("rst rdata", b32.o_rdata, 0);
      chk("rst ready", b32.o_ready, 1);
      chk("rst stall", b32.o_stall, 0);
      chk("rst ready64", b64.o_ready, 1);
      rst_n = 1'b1;
      tick();

      access32("SW", 0, 1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 0, 0);
      access32("SB", 0, 1, 3'b000, 32'h103, 32'h0000_00AA, 0, 0, 0);
      access32("LB", 1, 0, 3'b000, 32'h102, 0, 0, 32'h80FF_7F01, 0);
      access32("LBU", 1, 0, 3'b100, 32'h102, 0, 0, 32'h80FF_7F01, 1);
      access32("LH", 1, 0, 3'b001, 32'h102, 0, 1, 32'h80FF_7F01, 0);
      access32("LHU", 1, 0, 3'b101, 32'h100, 0, 0, 32'h80FF_7F01, 2);
      access32("LW mis", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0);
      access32("LH mis", 1, 0, 3'b001, 32'h101, 0, 0, 0, 0);
      access32("LD illegal", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0);
      access32("SH gnt3", 0, 1, 3'b001, 32'h20E, 32'h0000_1234, 3, 0, 0);
      access32("RW both", 1, 1, 3'b000, 32'h301, 32'h0000_0055, 0, 0, 0);

      // Neither direction: ignored. Stray rvalid in idle: ignored.
      b32.i_valid = 1'b1;
      b32.i_mem_rvalid = 1'b1;
      tick();
      b32.i_valid = 1'b0;
      b32.i_mem_rvalid = 1'b0;
      chk("nop valid", b32.o_valid, 0);
      chk("nop req", b32.o_mem_req, 0);
      chk("nop ready", b32.o_ready, 1);

      // Grant withheld 3 cycles, then reset while waiting for read data.
      b32.i_valid = 1'b1; b32.i_re = 1'b1; b32.i_funct3 = 3'b010; b32.i_addr = 32'h200;
      tick();
      b32.i_valid = 1'b0; b32.i_re = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp req", b32.o_mem_req, 1);
         chk("bp addr", b32.o_mem_addr, 32'h200);
         chk("bp be", b32.o_mem_be, 4'hF);
         chk("bp stall", b32.o_stall, 1);
         tick();
      end
      b32.i_mem_gnt = 1'b1;
      tick();
      b32.i_mem_gnt = 1'b0;
      chk("bp wait stall", b32.o_stall, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid rst ready", b32.o_ready, 1);
      chk("mid rst req", b32.o_mem_req, 0);
      chk("mid rst addr", b32.o_mem_addr, 0);
      chk("mid rst valid", b32.o_valid, 0);
      b32.i_mem_rvalid = 1'b1; b32.i_mem_rdata = 32'h1234_5678;
      tick();
      b32.i_mem_rvalid = 1'b0;
      chk("late rvalid valid", b32.o_valid, 0);
      chk("late rvalid rdata", b32.o_rdata, 0);

      for (int n = 0; n < 60; n++) begin
         int unsigned dir = $urandom_range(1, 3);
         access32("rand", dir[0], dir[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom_range(0, 2), $urandom, $urandom_range(0, 2));
      end

      // 64-bit instance.
      b64.i_valid = 1'b1; b64.i_re = 1'b1; b64.i_funct3 = 3'b110; b64.i_addr = 32'h1004;
      tick();
      b64.i_valid = 1'b0; b64.i_re = 1'b0;
      chk("LWU64 req", b64.o_mem_req, 1);
      chk("LWU64 addr", b64.o_mem_addr, 32'h1000);
      b64.i_mem_gnt = 1'b1;
      tick();
      b64.i_mem_gnt = 1'b0;
      b64.i_mem_rvalid = 1'b1; b64.i_mem_rdata = 64'hFFFF_FFFF_0000_0000;
      tick();
      b64.i_mem_rvalid = 1'b0;
      chk("LWU64 valid", b64.o_valid, 1);
      chk("LWU64 rdata", b64.o_rdata, 64'h0000_0000_FFFF_FFFF);

      b64.i_valid = 1'b1; b64.i_re = 1'b1; b64.i_funct3 = 3'b010; b64.i_addr = 32'h1004;
      tick();
      b64.i_valid = 1'b0; b64.i_re = 1'b0;
      b64.i_mem_gnt = 1'b1;
      tick();
      b64.i_mem_gnt = 1'b0;
      b64.i_mem_rvalid = 1'b1; b64.i_mem_rdata = 64'h8000_0000_0000_0000;
      tick();
      b64.i_mem_rvalid = 1'b0;
      chk("LW64 rdata", b64.o_rdata,
          ld_model(3'b010, 32'h1004, 64'h8000_0000_0000_0000, 64));

      b64.i_valid = 1'b1; b64.i_we = 1'b1; b64.i_funct3 = 3'b011; b64.i_addr = 32'h1004;
      tick();
      b64.i_valid = 1'b0; b64.i_we = 1'b0;
      chk("SD64 mis valid", b64.o_valid, 1);
      chk("SD64 mis flag", b64.o_misaligned, 1);
      chk("SD64 mis req", b64.o_mem_req, 0);

      b64.i_valid = 1'b1; b64.i_we = 1'b1; b64.i_funct3 = 3'b011; b64.i_addr = 32'h1008;
      b64.i_wdata = 64'h1122_3344_5566_7788;
      tick();
      b64.i_valid = 1'b0; b64.i_we = 1'b0;
      chk("SD64 be", b64.o_mem_be, 8'hFF);
      chk("SD64 addr", b64.o_mem_addr, 32'h1008);
      chk("SD64 wdata", b64.o_mem_wdata, 64'h1122_3344_5566_7788);
      b64.i_mem_gnt = 1'b1;
      tick();
      b64.i_mem_gnt = 1'b0;
      chk("SD64 valid", b64.o_valid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
